// File: rtl/intr_ack_sequencer.sv
// intr_ack_sequencer: two-pulse INTA sequencer that captures the PIC vector byte and offers it over valid/ready
module intr_ack_sequencer #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_to_cpu,
  input  logic       cpu_int_enable,
  input  logic [7:0] data_bus_in,
  output logic       interrupt_acknowledge_n,
  output logic       vector_valid,
  output logic [7:0] vector,
  output logic       vector_spurious,
  input  logic       vector_ready,
  output logic       busy
);
  localparam int MX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MX) + 1;
  localparam logic [CW-1:0] PL = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GL = CW'(GAP_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, ACK1, GAP, ACK2, HOLD} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic int_m, int_s, cap;
  always_ff @(posedge clock) begin
    if (reset) begin
      int_m <= 1'b0;
      int_s <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      interrupt_acknowledge_n <= 1'b1;
      vector <= 8'h00;
      vector_spurious <= 1'b0;
    end else begin
      int_m <= interrupt_to_cpu;
      int_s <= int_m;
      state <= state_nxt;
      cnt <= cnt_nxt;
      // registered from next state so INTA# tracks ACK1/ACK2 without glitches
      interrupt_acknowledge_n <= !(state_nxt == ACK1 || state_nxt == ACK2);
      if (cap) begin
        vector <= data_bus_in;
        vector_spurious <= ~int_s;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    cap = 1'b0;
    case (state)
      IDLE: if (int_s && cpu_int_enable) begin
        state_nxt = ACK1;
        cnt_nxt = PL;
      end
      ACK1: if (cnt == '0) begin
        state_nxt = GAP;
        cnt_nxt = GL;
      end else cnt_nxt = cnt - CW'(1);
      GAP: if (cnt == '0) begin
        state_nxt = ACK2;
        cnt_nxt = PL;
      end else cnt_nxt = cnt - CW'(1);
      ACK2: if (cnt == '0) begin
        state_nxt = HOLD;
        cap = 1'b1;
      end else cnt_nxt = cnt - CW'(1);
      HOLD: state_nxt = vector_ready ? IDLE : HOLD;
      default: state_nxt = IDLE;
    endcase
  end
  assign vector_valid = state == HOLD;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_intr_ack_sequencer.sv
// tb_intr_ack_sequencer: timeline model of the INTA sequence checked every cycle, plus directed literal checks
module tb_intr_ack_sequencer;
  localparam int P = 2;
  localparam int G = 2;
  localparam int L = 2 * P + G;
  logic clock, reset, intr, en, ready;
  logic [7:0] bus;
  logic inta_n, vector_valid, vector_spurious, busy;
  logic [7:0] vector;
  int total = 0;
  int bad = 0;
  intr_ack_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clock(clock), .reset(reset), .interrupt_to_cpu(intr), .cpu_int_enable(en),
    .data_bus_in(bus), .interrupt_acknowledge_n(inta_n), .vector_valid(vector_valid),
    .vector(vector), .vector_spurious(vector_spurious), .vector_ready(ready), .busy(busy)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: the sequence is a timeline t=0..L after start; low windows [0,P) and [P+G,L), vector at t=L
  logic m_s1 = 0, m_s2 = 0, m_act = 0, m_spur = 0;
  int m_t = 0;
  logic [7:0] m_vec = 0;
  initial forever begin
    @(posedge clock);
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_act = 0; m_t = 0; m_vec = 0; m_spur = 0;
    end else begin
      if (!m_act) begin
        if (m_s2 && en) begin m_act = 1; m_t = 0; end
      end else if (m_t < L) begin
        m_t++;
        if (m_t == L) begin m_vec = bus; m_spur = !m_s2; end
      end else if (ready) m_act = 0;
      m_s2 = m_s1;
      m_s1 = intr;
    end
    #1;
    chk("m_inta_n", 8'(inta_n), 8'(!(m_act && (m_t < P || (m_t >= P + G && m_t < L)))));
    chk("m_valid", 8'(vector_valid), 8'(m_act && m_t == L));
    chk("m_busy", 8'(busy), 8'(m_act));
    chk("m_vector", vector, m_vec);
    chk("m_spurious", 8'(vector_spurious), 8'(m_spur));
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1; intr = 0; en = 0; bus = 0; ready = 0;
    repeat (2) @(negedge clock);
    chk("rst_inta_n", 8'(inta_n), 8'd1);
    chk("rst_valid", 8'(vector_valid), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_vector", vector, 8'h00);
    reset = 0;
    intr = 1; en = 1; bus = 8'h4A;
    repeat (2) @(negedge clock);
    chk("basic_pre_ack", 8'(inta_n), 8'd1);
    @(negedge clock);
    chk("basic_ack1", 8'(inta_n), 8'd0);
    repeat (2) @(negedge clock);
    chk("basic_gap", 8'(inta_n), 8'd1);
    repeat (2) @(negedge clock);
    chk("basic_ack2", 8'(inta_n), 8'd0);
    repeat (2) @(negedge clock);
    chk("basic_valid", 8'(vector_valid), 8'd1);
    chk("basic_vector", vector, 8'h4A);
    chk("basic_spur", 8'(vector_spurious), 8'd0);
    ready = 1; en = 0; intr = 0;
    @(negedge clock);
    chk("basic_xfer_valid", 8'(vector_valid), 8'd0);
    chk("basic_xfer_busy", 8'(busy), 8'd0);
    intr = 1; en = 0; ready = 1;
    repeat (20) @(negedge clock);
    chk("masked_inta_n", 8'(inta_n), 8'd1);
    chk("masked_busy", 8'(busy), 8'd0);
    en = 1; ready = 0; bus = 8'h11;
    @(negedge clock);
    chk("unmask_ack1", 8'(inta_n), 8'd0);
    repeat (6) @(negedge clock);
    chk("unmask_valid", 8'(vector_valid), 8'd1);
    chk("unmask_vector", vector, 8'h11);
    ready = 1; intr = 0; en = 0;
    @(negedge clock);
    ready = 0;
    repeat (3) @(negedge clock);
    intr = 1; en = 1; bus = 8'h4F;
    repeat (3) @(negedge clock);
    chk("spur_ack1", 8'(inta_n), 8'd0);
    repeat (2) @(negedge clock);
    intr = 0; en = 0;
    repeat (4) @(negedge clock);
    chk("spur_valid", 8'(vector_valid), 8'd1);
    chk("spur_vector", vector, 8'h4F);
    chk("spur_flag", 8'(vector_spurious), 8'd1);
    ready = 1;
    @(negedge clock);
    ready = 0;
    chk("spur_done_busy", 8'(busy), 8'd0);
    repeat (3) @(negedge clock);
    intr = 1; en = 1; bus = 8'h5C;
    for (int i = 0; i < 40 && !vector_valid; i++) @(negedge clock);
    chk("bp_valid_seen", 8'(vector_valid), 8'd1);
    bus = 8'hFF;
    repeat (5) begin
      @(negedge clock);
      chk("bp_hold_valid", 8'(vector_valid), 8'd1);
      chk("bp_hold_vector", vector, 8'h5C);
      chk("bp_hold_busy", 8'(busy), 8'd1);
    end
    ready = 1;
    @(negedge clock);
    ready = 0;
    chk("bp_xfer_valid", 8'(vector_valid), 8'd0);
    chk("bp_idle_busy", 8'(busy), 8'd0);
    chk("bp_idle_inta_n", 8'(inta_n), 8'd1);
    @(negedge clock);
    chk("bp_restart_ack1", 8'(inta_n), 8'd0);
    repeat (4) @(negedge clock);
    chk("rst_mid_ack2", 8'(inta_n), 8'd0);
    reset = 1; intr = 0; en = 0;
    @(negedge clock);
    chk("rst_mid_inta_n", 8'(inta_n), 8'd1);
    chk("rst_mid_busy", 8'(busy), 8'd0);
    chk("rst_mid_valid", 8'(vector_valid), 8'd0);
    @(negedge clock);
    chk("rst_mid_vector", vector, 8'h00);
    reset = 0;
    repeat (5) @(negedge clock);
    chk("post_rst_valid", 8'(vector_valid), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
